// File: rtl/bus_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// bus_mem_responder_pkg : shared write-length codes, MMIO offsets, ERR bits
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package bus_mem_responder_pkg;

    localparam logic [2:0] MEM_WRITE_BYTE = 3'b000;
    localparam logic [2:0] MEM_WRITE_HALF = 3'b001;
    localparam logic [2:0] MEM_WRITE_WORD = 3'b010;

    typedef enum logic [1:0] {
        MMIO_TX_DATA   = 2'd0,
        MMIO_TX_STATUS = 2'd1,
        MMIO_CYCLE     = 2'd2,
        MMIO_ERR       = 2'd3
    } mmio_reg_e;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_W        = 2;

    // A write is legal only for the three defined lengths at natural alignment.
    function automatic logic write_is_legal(input logic [2:0] len, input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        case (len)
            MEM_WRITE_BYTE: ok = 1'b1;
            MEM_WRITE_HALF: ok = ~lo[0];
            MEM_WRITE_WORD: ok = (lo == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] len, input logic [1:0] lo);
        logic [3:0] m;
        m = 4'b0000;
        case (len)
            MEM_WRITE_BYTE: m = 4'b0001 << lo;
            MEM_WRITE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
            MEM_WRITE_WORD: m = 4'b1111;
            default:        m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_mem_responder_tx_fifo.sv
// -----------------------------------------------------------------------------
// bus_tx_fifo : console TX byte FIFO, synchronous push/pop, no fall-through
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module bus_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the push overwrites.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= push_data;
        end
    end

    assign data  = fifo_mem[rd_ptr_q];
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/bus_mem_responder.sv
// -----------------------------------------------------------------------------
// bus_mem_responder : data-bus responder with RAM and MMIO (TX FIFO, CYCLE, ERR)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_wr_data,
    input  logic        bus_wr_enable,
    input  logic [2:0]  bus_write_length,
    output logic [31:0] bus_read_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

    logic [31:0] ram_mem [MEM_WORDS];

    logic                       is_ram;
    logic                       is_mmio;
    logic                       legal;
    logic                       mapped_wr;
    logic [IDX_W-1:0]           ram_idx;
    logic [3:0]                 lane_we;
    logic [31:0]                lane_data;
    mmio_reg_e                  mmio_reg;
    logic                       mmio_wr;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [31:0]                cycle_q, cycle_d;
    logic [ERR_W-1:0]           err_q, err_d;
    logic [ERR_W-1:0]           err_set;
    logic [ERR_W-1:0]           err_clr;
    logic [31:0]                mmio_word;
    logic [31:0]                sel_word;

    assign is_ram    = ({1'b0, bus_address} < RAM_BYTES);
    assign is_mmio   = (bus_address[31:4] == MMIO_BASE[31:4]);
    assign legal     = write_is_legal(bus_write_length, bus_address[1:0]);
    // Unmapped writes are silently dropped, so only mapped ones can raise ERR.
    assign mapped_wr = bus_wr_enable && (is_ram || is_mmio);
    assign ram_idx   = bus_address[IDX_W+1:2];
    assign mmio_reg  = mmio_reg_e'(bus_address[3:2]);
    assign mmio_wr   = bus_wr_enable && is_mmio && legal;

    always_comb begin
        lane_data = bus_wr_data;
        lane_we   = 4'b0000;
        case (bus_write_length)
            MEM_WRITE_BYTE: lane_data = {4{bus_wr_data[7:0]}};
            MEM_WRITE_HALF: lane_data = {2{bus_wr_data[15:0]}};
            default:        lane_data = bus_wr_data;
        endcase
        if (bus_wr_enable && is_ram && legal) begin
            lane_we = lane_mask(bus_write_length, bus_address[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[i]) begin
                ram_mem[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    assign fifo_push = mmio_wr && (mmio_reg == MMIO_TX_DATA);
    assign fifo_pop  = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty;

    bus_tx_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (bus_wr_data[7:0]),
        .pop       (fifo_pop),
        .data      (tx_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (mmio_wr && (mmio_reg == MMIO_CYCLE)) begin
            cycle_d = bus_wr_data;
        end

        err_set               = '0;
        err_set[ERR_MISALIGN] = mapped_wr && !legal;
        err_set[ERR_OVERFLOW] = fifo_push && fifo_full && !fifo_pop;
        err_clr               = '0;
        if (mmio_wr && (mmio_reg == MMIO_ERR)) begin
            err_clr = bus_wr_data[ERR_W-1:0];
        end
        // Set has priority over a same-cycle write-1-to-clear.
        err_d = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
            err_q   <= '0;
        end else begin
            cycle_q <= cycle_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mmio_word = '0;
        case (mmio_reg)
            MMIO_TX_STATUS: mmio_word = {16'h0000, 8'(fifo_count), 6'b000000, fifo_full, fifo_empty};
            MMIO_CYCLE:     mmio_word = cycle_q;
            MMIO_ERR:       mmio_word = {{(32-ERR_W){1'b0}}, err_q};
            default:        mmio_word = '0;
        endcase

        sel_word = '0;
        if (is_ram) begin
            sel_word = ram_mem[ram_idx];
        end else if (is_mmio) begin
            sel_word = mmio_word;
        end
        bus_read_data = sel_word >> {bus_address[1:0], 3'b000};
    end

endmodule

`default_nettype wire
